fc_argmax_reader: RTL
=====================

Name: fc_argmax_reader

Overview:
- Consumer side of the FC result write-back: once the FC scheduler reports done, this block reads the NUM_CLASS FC outputs from picture memory (addresses RD_BASE_ADDR .. RD_BASE_ADDR+NUM_CLASS-1).
- It finds the signed maximum and presents the winning class index and value to the CPU/host through a valid/ack handshake.
- It owns the picture-memory read port while busy and never writes memory.

Parameters:
- ADDR_BIT, 10, picture memory address width
- DATA_BIT, 16, width of one FC output word, signed two's complement
- RD_BASE_ADDR, 16, first FC result address
- NUM_CLASS, 10, number of FC outputs to scan (>= 2)
- CLASS_BIT, 4, width of class index (2^CLASS_BIT >= NUM_CLASS)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a scan; sampled only in IDLE
- picture_mem_addr  out  ADDR_BIT  read address
- picture_mem_re  out  1  read enable, high while issuing addresses
- picture_mem_rd_data  in  DATA_BIT  read data, valid the cycle after the address (synchronous read)
- result_valid  out  1  class_idx/max_value valid; held until acked
- result_ack  in  1  consumer accepts result
- class_idx  out  CLASS_BIT  index of the maximum FC output
- max_value  out  DATA_BIT  value of the maximum FC output
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low (rst_n). On reset every register clears: state=IDLE, all outputs 0, picture_mem_addr=0, class_idx=0, max_value=0.
- States: IDLE, READ, LAST, HOLD.
- IDLE: busy=0, re=0, addr=0. start=1 -> READ. The read counter rd_cnt clears to 0.
- READ: re=1, addr=RD_BASE_ADDR+rd_cnt (ADDR_BIT wrap, no saturation). rd_cnt increments each cycle. When rd_cnt==NUM_CLASS-1 -> LAST.
- LAST: re=0, addr=0. Consumes the final read word -> HOLD.
- Data pipeline:
  - A registered flag data_vld follows re by one cycle; a registered index cmp_idx follows rd_cnt by one cycle.
  - When data_vld=1 and cmp_idx==0: max_value <= rd_data and class_idx <= 0, unconditionally.
  - When data_vld=1 and cmp_idx>0: update only if $signed(rd_data) > $signed(max_value). The comparison is strict, so on a tie the lowest index wins.
- HOLD: result_valid=1; class_idx and max_value are stable. result_ack=1 -> IDLE, and result_valid drops the next cycle.
- Latency: start sampled at edge k -> first address at edge k (addr visible after k), result_valid visible after edge k+NUM_CLASS+2 (12 cycles at default).
- Between scans: class_idx and max_value keep their last values after ack. They are overwritten only by the next scan's first word.
- start outside IDLE is ignored, including start and result_ack high together in HOLD. A new scan needs start in IDLE.
- result_ack outside HOLD is ignored. result_ack held high continuously completes HOLD in one cycle.
- Reset asserted mid-scan or in HOLD aborts immediately to the reset values. No partial result is presented.
- Memory is never written; the write enable is the producer's responsibility. The integrator muxes picture_mem_addr using busy.

Decomposition:
- Shared package fc_pkg:
  - state encoding localparams IDLE=0, READ=1, LAST=2, HOLD=3 (2-bit)
  - FC_RD_BASE_ADDR=16, FC_NUM_CLASS=10, also reused by the FC scheduler's write base
- Natural sub-module argmax_unit:
  - inputs: clk, rst_n, data_vld, first, idx, data
  - outputs: registered max_value, class_idx
  - contains the signed strict-greater compare
- The top level holds the FSM, rd_cnt and the handshake.

Test Plan:
- Basic scan: memory[16..25] = {3,-5,7,2,9,1,0,-1,4,8}; start pulse -> addresses 16..25 on consecutive cycles with re=1; result_valid after 12 cycles; class_idx=4, max_value=9; ack -> IDLE next cycle, busy=0.
- Signed/negative: all values negative {-100,-3,-50,-3,-7,-9,-8,-20,-30,-40} -> class_idx=1, max_value=-3. Checks signed compare and tie to lowest index.
- Extremes: memory[25]=16'h7FFF, memory[16]=16'h8000, others 0 -> class_idx=9, max_value=32767. Then all equal 5 -> class_idx=0.
- Handshake: hold result_ack=0 for 20 cycles in HOLD -> result_valid and outputs stable. Assert start while in READ and in HOLD -> ignored, no rescan. ack and start together in HOLD -> IDLE only; a later start runs a full new scan.
- Reset mid-operation: deassert rst_n during READ at rd_cnt=5 -> all outputs 0, state IDLE, re=0 asynchronously. After release, start -> full correct scan from address 16.
- Back-to-back: ack and start asserted on consecutive cycles with different memory contents -> second result reflects only the new data (first word overwrites max_value).

Source files
------------

// File: rtl/fc_pkg.sv
// Shared FC definitions: reader FSM encoding and the FC result window,
// which is also where the FC scheduler writes its outputs.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2,
    HOLD = 2'd3
  } fc_state_e;

  localparam int FC_RD_BASE_ADDR = 16;
  localparam int FC_NUM_CLASS    = 10;

endpackage

// File: rtl/fc_argmax_reader_if.sv
// Picture-memory read port plus the result handshake towards the host.
//
// Handshake: result_valid rises with class_idx/max_value already stable and
// stays high, with the payload frozen, until a cycle in which result_ack is
// sampled high; result_valid drops on the following cycle. result_ack is
// ignored whenever result_valid is low.
interface fc_argmax_reader_if #(
  parameter int ADDR_BIT  = 10,
  parameter int DATA_BIT  = 16,
  parameter int CLASS_BIT = 4
);

  logic [ADDR_BIT-1:0]  picture_mem_addr;
  logic                 picture_mem_re;
  logic [DATA_BIT-1:0]  picture_mem_rd_data;
  logic                 result_valid;
  logic                 result_ack;
  logic [CLASS_BIT-1:0] class_idx;
  logic [DATA_BIT-1:0]  max_value;

  // Reader side: drives the memory address and presents the result
  modport master (
    output picture_mem_addr,
    output picture_mem_re,
    input  picture_mem_rd_data,
    output result_valid,
    input  result_ack,
    output class_idx,
    output max_value
  );

  // Memory / host side
  modport slave (
    input  picture_mem_addr,
    input  picture_mem_re,
    output picture_mem_rd_data,
    input  result_valid,
    output result_ack,
    input  class_idx,
    input  max_value
  );

endinterface

// File: rtl/fc_argmax_reader_argmax_unit.sv
// Running signed argmax over a stream of indexed words. The first word of a
// scan loads unconditionally; later words replace the best only when strictly
// greater, so ties keep the lowest index.
module argmax_unit #(
  parameter int DATA_BIT  = 16,
  parameter int CLASS_BIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_vld,
  input  logic                 first,
  input  logic [CLASS_BIT-1:0] idx,
  input  logic [DATA_BIT-1:0]  data,
  output logic [DATA_BIT-1:0]  max_value,
  output logic [CLASS_BIT-1:0] class_idx
);

  logic [DATA_BIT-1:0]  max_value_q, max_value_d;
  logic [CLASS_BIT-1:0] class_idx_q, class_idx_d;

  // Next best value/index: load on first word, replace on strict greater
  always_comb begin
    max_value_d = max_value_q;
    class_idx_d = class_idx_q;
    if (data_vld) begin
      if (first || ($signed(data) > $signed(max_value_q))) begin
        max_value_d = data;
        class_idx_d = idx;
      end
    end
  end

  // Best-so-far registers, cleared by reset only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_value_q <= '0;
      class_idx_q <= '0;
    end else begin
      max_value_q <= max_value_d;
      class_idx_q <= class_idx_d;
    end
  end

  assign max_value = max_value_q;
  assign class_idx = class_idx_q;

endmodule

// File: rtl/fc_argmax_reader.sv
// Scans the FC result window in picture memory after the FC scheduler is done,
// finds the signed maximum and hands class index and value to the host.
// Memory read is synchronous: data returns the cycle after the address.
module fc_argmax_reader
  import fc_pkg::*;
#(
  parameter int ADDR_BIT     = 10,
  parameter int DATA_BIT     = 16,
  parameter int RD_BASE_ADDR = FC_RD_BASE_ADDR,
  parameter int NUM_CLASS    = FC_NUM_CLASS,
  parameter int CLASS_BIT    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output fc_state_e           state_dbg,
  fc_argmax_reader_if.master  bus
);

  localparam logic [ADDR_BIT-1:0]  BASE     = ADDR_BIT'(RD_BASE_ADDR);
  localparam logic [CLASS_BIT-1:0] LAST_IDX = CLASS_BIT'(NUM_CLASS - 1);

  fc_state_e            state_q, state_d;
  logic [CLASS_BIT-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_BIT-1:0]  addr_q, addr_d;
  logic                 re_q, re_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 data_vld_q, data_vld_d;
  logic [CLASS_BIT-1:0] cmp_idx_q, cmp_idx_d;

  // FSM next-state and next registered outputs
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    addr_d     = addr_q;
    re_d       = re_q;
    valid_d    = valid_q;
    data_vld_d = re_q;
    cmp_idx_d  = rd_cnt_q;
    unique case (state_q)
      IDLE: begin
        rd_cnt_d = '0;
        addr_d   = '0;
        re_d     = 1'b0;
        valid_d  = 1'b0;
        if (start) begin
          state_d = READ;
          addr_d  = BASE;
          re_d    = 1'b1;
        end
      end
      READ: begin
        if (rd_cnt_q == LAST_IDX) begin
          state_d = LAST;
          addr_d  = '0;
          re_d    = 1'b0;
        end else begin
          rd_cnt_d = rd_cnt_q + CLASS_BIT'(1);
          addr_d   = BASE + ADDR_BIT'(rd_cnt_q) + ADDR_BIT'(1);
          re_d     = 1'b1;
        end
      end
      LAST: begin
        // Leave only once the final word has been folded into the argmax
        // registers, so the payload is settled when result_valid rises.
        if (!data_vld_q) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.result_ack) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
        re_d    = 1'b0;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM, read counter, output and read-pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      addr_q     <= '0;
      re_q       <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      data_vld_q <= 1'b0;
      cmp_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      data_vld_q <= data_vld_d;
      cmp_idx_q  <= cmp_idx_d;
    end
  end

  argmax_unit #(
    .DATA_BIT  (DATA_BIT),
    .CLASS_BIT (CLASS_BIT)
  ) u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_vld  (data_vld_q),
    .first     (cmp_idx_q == '0),
    .idx       (cmp_idx_q),
    .data      (bus.picture_mem_rd_data),
    .max_value (bus.max_value),
    .class_idx (bus.class_idx)
  );

  assign bus.picture_mem_addr = addr_q;
  assign bus.picture_mem_re   = re_q;
  assign bus.result_valid     = valid_q;
  assign busy                 = busy_q;
  assign state_dbg            = state_q;

endmodule
